// File: rtl/id_stage.sv
// ============================================================================
// id_stage : RV32I decode stage with load-use bubble insertion and an
//            internal ID/EX output register (valid/ready, flush).
// Rev 1.0
// ============================================================================
`default_nettype none

module id_stage #(
  parameter int XLEN      = 32,
  parameter int CNT_W     = 16,
  parameter int HAZARD_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      inst_addr_i,
  output logic [4:0]       rs1_addr_o,
  output logic [4:0]       rs2_addr_o,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  input  logic             flush_i,
  input  logic             ex_ready_i,
  output logic             out_valid_o,
  output logic [31:0]      inst_o,
  output logic [31:0]      inst_addr_o,
  output logic [XLEN-1:0]  op1_o,
  output logic [XLEN-1:0]  op2_o,
  output logic [XLEN-1:0]  imm_o,
  output logic [4:0]       rd_addr_o,
  output logic             reg_wen_o,
  output logic             is_load_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;

  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic signed [11:0] w_i12;
  logic signed [12:0] w_b13;
  logic signed [20:0] w_j21;
  logic signed [31:0] w_u32;
  logic [XLEN-1:0] w_i_imm, w_b_imm, w_j_imm, w_u_imm, w_pc, w_shamt;

  assign w_funct3 = inst_i[14:12];
  assign w_funct7 = inst_i[31:25];
  assign w_i12    = inst_i[31:20];
  assign w_b13    = {inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign w_j21    = {inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign w_u32    = {inst_i[31:12], 12'h000};
  // Size casts of signed values sign-extend to XLEN.
  assign w_i_imm  = XLEN'(w_i12);
  assign w_b_imm  = XLEN'(w_b13);
  assign w_j_imm  = XLEN'(w_j21);
  assign w_u_imm  = XLEN'(w_u32);
  assign w_pc     = XLEN'(inst_addr_i);
  assign w_shamt  = XLEN'(inst_i[24:20]);

  logic            w_rd1, w_rd2, w_wr, w_ld, w_ill;
  logic [XLEN-1:0] w_op1, w_op2, w_imm;
  logic [4:0]      w_rd;

  always_comb begin
    w_rd1 = 1'b0;
    w_rd2 = 1'b0;
    w_wr  = 1'b0;
    w_ld  = 1'b0;
    w_ill = 1'b0;
    w_op1 = '0;
    w_op2 = '0;
    w_imm = '0;
    unique case (inst_i[6:0])
      c_OPC_OPIMM: begin
        w_rd1 = 1'b1;
        w_wr  = 1'b1;
        w_op1 = rs1_data_i;
        w_op2 = (w_funct3 == 3'b001 || w_funct3 == 3'b101) ? w_shamt : w_i_imm;
        w_imm = w_i_imm;
      end
      c_OPC_OP: begin
        if (w_funct7 == 7'b0000000 ||
            (w_funct7 == 7'b0100000 && (w_funct3 == 3'b000 || w_funct3 == 3'b101))) begin
          w_rd1 = 1'b1;
          w_rd2 = 1'b1;
          w_wr  = 1'b1;
          w_op1 = rs1_data_i;
          w_op2 = rs2_data_i;
        end else begin
          w_ill = 1'b1;
        end
      end
      c_OPC_BRANCH: begin
        if (w_funct3 != 3'b010 && w_funct3 != 3'b011) begin
          w_rd1 = 1'b1;
          w_rd2 = 1'b1;
          w_op1 = rs1_data_i;
          w_op2 = rs2_data_i;
          w_imm = w_b_imm;
        end else begin
          w_ill = 1'b1;
        end
      end
      c_OPC_JAL: begin
        w_wr  = 1'b1;
        w_op1 = w_pc;
        w_op2 = XLEN'(4);
        w_imm = w_j_imm;
      end
      c_OPC_JALR: begin
        if (w_funct3 == 3'b000) begin
          w_rd1 = 1'b1;
          w_wr  = 1'b1;
          w_op1 = rs1_data_i;
          w_op2 = w_i_imm;
          w_imm = w_i_imm;
        end else begin
          w_ill = 1'b1;
        end
      end
      c_OPC_LUI: begin
        w_wr  = 1'b1;
        w_op2 = w_u_imm;
        w_imm = w_u_imm;
      end
      c_OPC_AUIPC: begin
        w_wr  = 1'b1;
        w_op1 = w_pc;
        w_op2 = w_u_imm;
        w_imm = w_u_imm;
      end
      c_OPC_LOAD: begin
        if (w_funct3 == 3'b010) begin
          w_rd1 = 1'b1;
          w_wr  = 1'b1;
          w_ld  = 1'b1;
          w_op1 = rs1_data_i;
          w_op2 = w_i_imm;
          w_imm = w_i_imm;
        end else begin
          w_ill = 1'b1;
        end
      end
      default: w_ill = 1'b1;
    endcase
  end

  assign w_rd       = w_wr ? inst_i[11:7] : 5'd0;
  assign rs1_addr_o = w_rd1 ? inst_i[19:15] : 5'd0;
  assign rs2_addr_o = w_rd2 ? inst_i[24:20] : 5'd0;

  logic             r_valid, r_wen, r_ld, r_ill;
  logic [31:0]      r_inst, r_addr;
  logic [XLEN-1:0]  r_op1, r_op2, r_imm;
  logic [4:0]       r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic             w_adv, w_hazard;

  assign w_adv    = !r_valid || ex_ready_i;
  assign w_hazard = (HAZARD_EN != 0) && in_valid_i && r_valid && r_ld && (r_rd != 5'd0) &&
                    ((w_rd1 && inst_i[19:15] == r_rd) || (w_rd2 && inst_i[24:20] == r_rd));
  assign in_ready_o = flush_i || (w_adv && !w_hazard);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_inst  <= '0;
      r_addr  <= '0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_imm   <= '0;
      r_rd    <= '0;
      r_wen   <= 1'b0;
      r_ld    <= 1'b0;
      r_ill   <= 1'b0;
      r_cnt   <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
      r_inst  <= '0;
      r_addr  <= '0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_imm   <= '0;
      r_rd    <= '0;
      r_wen   <= 1'b0;
      r_ld    <= 1'b0;
      r_ill   <= 1'b0;
    end else if (w_adv) begin
      if (w_hazard) begin
        r_valid <= 1'b0;
        if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
      end else if (in_valid_i) begin
        r_valid <= 1'b1;
        r_inst  <= inst_i;
        r_addr  <= inst_addr_i;
        r_op1   <= w_op1;
        r_op2   <= w_op2;
        r_imm   <= w_imm;
        r_rd    <= w_rd;
        r_wen   <= w_wr && (w_rd != 5'd0);
        r_ld    <= w_ld;
        r_ill   <= w_ill;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid_o = r_valid;
  assign inst_o      = r_inst;
  assign inst_addr_o = r_addr;
  assign op1_o       = r_op1;
  assign op2_o       = r_op2;
  assign imm_o       = r_imm;
  assign rd_addr_o   = r_rd;
  assign reg_wen_o   = r_wen;
  assign is_load_o   = r_ld;
  assign illegal_o   = r_ill;
  assign stall_cnt_o = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus randomized stream against a
// behavioural decode/handshake model.
`default_nettype none

module tb_id_stage;

  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, exr = 1'b1;
  logic [31:0] inst = '0, addr = '0, r1d = '0, r2d = '0;

  logic        rdy, ov, wen, ld, ill;
  logic [4:0]  rs1a, rs2a, rd;
  logic [31:0] io, iao, op1, op2, imm;
  logic [CW-1:0] cnt;

  logic        n_rdy, n_ov, n_wen, n_ld, n_ill;
  logic [4:0]  n_rs1a, n_rs2a, n_rd;
  logic [31:0] n_io, n_iao, n_op1, n_op2, n_imm;
  logic [15:0] n_cnt;

  always #5 clk = ~clk;

  id_stage #(.XLEN(32), .CNT_W(CW), .HAZARD_EN(1)) u_dut (
    .clk(clk), .rst(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy),
    .inst_i(inst), .inst_addr_i(addr), .rs1_addr_o(rs1a), .rs2_addr_o(rs2a),
    .rs1_data_i(r1d), .rs2_data_i(r2d), .flush_i(flush), .ex_ready_i(exr),
    .out_valid_o(ov), .inst_o(io), .inst_addr_o(iao), .op1_o(op1), .op2_o(op2),
    .imm_o(imm), .rd_addr_o(rd), .reg_wen_o(wen), .is_load_o(ld),
    .illegal_o(ill), .stall_cnt_o(cnt)
  );

  id_stage #(.XLEN(32), .CNT_W(16), .HAZARD_EN(0)) u_dut_nh (
    .clk(clk), .rst(rst_n), .in_valid_i(in_valid), .in_ready_o(n_rdy),
    .inst_i(inst), .inst_addr_i(addr), .rs1_addr_o(n_rs1a), .rs2_addr_o(n_rs2a),
    .rs1_data_i(r1d), .rs2_data_i(r2d), .flush_i(flush), .ex_ready_i(exr),
    .out_valid_o(n_ov), .inst_o(n_io), .inst_addr_o(n_iao), .op1_o(n_op1), .op2_o(n_op2),
    .imm_o(n_imm), .rd_addr_o(n_rd), .reg_wen_o(n_wen), .is_load_o(n_ld),
    .illegal_o(n_ill), .stall_cnt_o(n_cnt)
  );

  typedef struct {
    logic [31:0] op1, op2, imm;
    logic [4:0]  rd;
    logic        wen, ld, ill, r1, r2, chk_imm;
  } dec_t;

  int n_cmp = 0;
  int n_err = 0;

  logic        m_valid = 1'b0, m_clr = 1'b1, m_rdy = 1'b1;
  logic [31:0] m_inst = '0, m_addr = '0;
  dec_t        m_d;
  int          m_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Immediates built arithmetically from the field weights of each format.
  function automatic dec_t ref_dec(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] a, input logic [31:0] b);
    dec_t d;
    int f3, f7, ii, bi, ji;
    logic [31:0] ui;
    logic w;
    d = '{default: '0};
    w = 1'b0;
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    ii = int'(ins[31:20]);
    if (ii >= 2048) ii -= 4096;
    bi = int'(ins[11:8]) * 2 + int'(ins[30:25]) * 32 + int'(ins[7]) * 2048 - int'(ins[31]) * 4096;
    ji = int'(ins[30:21]) * 2 + int'(ins[20]) * 2048 + int'(ins[19:12]) * 4096
         - int'(ins[31]) * (1 << 20);
    ui = {ins[31:12], 12'h000};
    case (ins[6:0])
      7'h13: begin
        d.r1 = 1; w = 1; d.op1 = a;
        d.op2 = (f3 == 1 || f3 == 5) ? 32'(ins[24:20]) : 32'(ii);
      end
      7'h33: if (f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5))) begin
        d.r1 = 1; d.r2 = 1; w = 1; d.op1 = a; d.op2 = b;
      end else d.ill = 1;
      7'h63: if (f3 != 2 && f3 != 3) begin
        d.r1 = 1; d.r2 = 1; d.op1 = a; d.op2 = b; d.imm = 32'(bi); d.chk_imm = 1;
      end else d.ill = 1;
      7'h6f: begin
        w = 1; d.op1 = pc; d.op2 = 32'd4; d.imm = 32'(ji); d.chk_imm = 1;
      end
      7'h67: if (f3 == 0) begin
        d.r1 = 1; w = 1; d.op1 = a; d.op2 = 32'(ii); d.imm = 32'(ii); d.chk_imm = 1;
      end else d.ill = 1;
      7'h37: begin w = 1; d.op2 = ui; end
      7'h17: begin w = 1; d.op1 = pc; d.op2 = ui; end
      7'h03: if (f3 == 2) begin
        d.r1 = 1; w = 1; d.ld = 1; d.op1 = a; d.op2 = 32'(ii);
      end else d.ill = 1;
      default: d.ill = 1;
    endcase
    if (d.ill) d.chk_imm = 1;
    d.rd  = w ? ins[11:7] : 5'd0;
    d.wen = w && (d.rd != 5'd0);
    return d;
  endfunction

  task automatic model_clear();
    m_valid = 1'b0;
    m_clr   = 1'b1;
    m_inst  = '0;
    m_addr  = '0;
    m_d     = '{default: '0};
    m_d.chk_imm = 1'b1;
  endtask

  task automatic check_outputs();
    check("out_valid", ov, m_valid);
    check("stall_cnt", cnt, m_cnt);
    if (m_valid || m_clr) begin
      check("inst_o", io, m_inst);
      check("inst_addr_o", iao, m_addr);
      check("op1", op1, m_d.op1);
      check("op2", op2, m_d.op2);
      check("rd", rd, m_d.rd);
      check("reg_wen", wen, m_d.wen);
      check("is_load", ld, m_d.ld);
      check("illegal", ill, m_d.ill);
      if (m_d.chk_imm) check("imm", imm, m_d.imm);
    end
  endtask

  // One clock: check combinational outputs, clock, advance model, check held outputs.
  task automatic cycle();
    dec_t d;
    logic adv, hz;
    #1;
    d   = ref_dec(inst, addr, r1d, r2d);
    adv = !m_valid || exr;
    hz  = in_valid && m_valid && m_d.ld && (m_d.rd != 0) &&
          ((d.r1 && inst[19:15] == m_d.rd) || (d.r2 && inst[24:20] == m_d.rd));
    m_rdy = flush || (adv && !hz);
    check("in_ready", rdy, m_rdy);
    check("rs1_addr", rs1a, d.r1 ? inst[19:15] : 5'd0);
    check("rs2_addr", rs2a, d.r2 ? inst[24:20] : 5'd0);
    @(posedge clk);
    if (flush) model_clear();
    else if (adv && hz) begin
      m_valid = 1'b0;
      if (m_cnt < CMAX) m_cnt++;
    end else if (adv && in_valid) begin
      m_valid = 1'b1; m_clr = 1'b0; m_inst = inst; m_addr = addr; m_d = d;
    end else if (adv) m_valid = 1'b0;
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] a,
                       input logic fl, input logic e);
    in_valid = v; inst = i; addr = a; flush = fl; exr = e;
  endtask

  function automatic logic [31:0] gen();
    logic [4:0] rd_f, rs1_f, rs2_f;
    logic [2:0] f3;
    logic [11:0] i12;
    logic [6:0] f7;
    logic [19:0] u20;
    rd_f  = 5'($urandom_range(0, 3));
    rs1_f = 5'($urandom_range(0, 3));
    rs2_f = 5'($urandom_range(0, 3));
    f3    = 3'($urandom);
    i12   = 12'($urandom);
    u20   = 20'($urandom);
    f7    = ($urandom_range(0, 9) == 0) ? 7'($urandom) : (($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20);
    case ($urandom_range(0, 9))
      0:       return {(f3 == 3'd1 || f3 == 3'd5) ? {f7, 5'($urandom)} : i12, rs1_f, f3, rd_f, 7'h13};
      1, 9:    return {f7, rs2_f, rs1_f, f3, rd_f, 7'h33};
      2, 3:    return {i12, rs1_f, ($urandom_range(0, 7) == 0) ? f3 : 3'b010, rd_f, 7'h03};
      4:       return {f7, rs2_f, rs1_f, f3, i12[4:0], 7'h63};
      5:       return {u20, rd_f, 7'h6f};
      6:       return {i12, rs1_f, ($urandom_range(0, 3) == 0) ? f3 : 3'b000, rd_f, 7'h67};
      7:       return {u20, rd_f, ($urandom_range(0, 1) == 0) ? 7'h37 : 7'h17};
      default: return $urandom;
    endcase
  endfunction

  localparam logic [31:0] c_ADDI = 32'h00500093;
  localparam logic [31:0] c_LW   = 32'h0000A103;
  localparam logic [31:0] c_ADD  = 32'h002101B3;
  localparam logic [31:0] c_JAL  = 32'h0080006F;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    #3;
    check("rst ov", ov, 0);
    check("rst in_ready", rdy, 1);
    check("rst cnt", cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // addi x1,x0,5
    r1d = 0; r2d = 0;
    drive(1, c_ADDI, 32'h0, 0, 1); cycle();
    check("addi ov", ov, 1); check("addi op1", op1, 0); check("addi op2", op2, 5);
    check("addi rd", rd, 1); check("addi wen", wen, 1); check("addi ill", ill, 0);

    // load-use: one bubble; HAZARD_EN=0 copy never stalls
    r1d = 32'h1000;
    drive(1, c_LW, 32'h4, 0, 1); cycle();
    r1d = 32'h55; r2d = 32'h55;
    drive(1, c_ADD, 32'h8, 0, 1);
    #1;
    check("lu in_ready", rdy, 0);
    check("lu rs1a", rs1a, 2); check("lu rs2a", rs2a, 2);
    check("nh in_ready", n_rdy, 1);
    cycle();
    check("lu bubble ov", ov, 0); check("lu cnt", cnt, 1);
    check("nh ov", n_ov, 1); check("nh inst", n_io, c_ADD); check("nh cnt", n_cnt, 0);
    cycle();
    check("lu add ov", ov, 1); check("lu add inst", io, c_ADD);
    check("nh cnt2", n_cnt, 0);
    drive(0, 0, 0, 0, 1); cycle();

    // jal x0,8 at 0x100
    drive(1, c_JAL, 32'h100, 0, 1); cycle();
    check("jal op1", op1, 32'h100); check("jal op2", op2, 4); check("jal imm", imm, 8);
    check("jal rd", rd, 0); check("jal wen", wen, 0);

    // backpressure for 3 cycles
    drive(1, 32'h00700293, 32'h200, 0, 1); cycle();
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h00900313, 32'h204, 0, 0);
      cycle();
      check("bp hold inst", io, 32'h00700293);
      check("bp in_ready", m_rdy, 0);
    end
    drive(1, 32'h00900313, 32'h204, 0, 1); cycle();
    check("bp next inst", io, 32'h00900313);
    drive(0, 0, 0, 0, 1); cycle();
    check("bp no dup", ov, 0);

    // illegal, then flush with valid add under backpressure
    drive(1, 32'hFFFFFFFF, 32'h300, 0, 1); cycle();
    check("ill ov", ov, 1); check("ill flag", ill, 1); check("ill wen", wen, 0);
    check("ill op1", op1, 0); check("ill op2", op2, 0);
    drive(1, c_ADD, 32'h304, 1, 0); cycle();
    check("flush ov", ov, 0); check("flush inst", io, 0);
    drive(0, 0, 0, 0, 1); cycle();

    // saturation: 5 more load-use pairs
    for (int k = 0; k < 5; k++) begin
      drive(1, c_LW, 32'h400, 0, 1); cycle();
      drive(1, c_ADD, 32'h404, 0, 1); cycle(); cycle();
    end
    check("sat cnt", cnt, CMAX);

    // async reset while stalled
    drive(1, c_LW, 32'h500, 0, 1); cycle();
    drive(1, c_ADD, 32'h504, 0, 0); cycle();
    #1 rst_n = 1'b0;
    #1;
    check("ar ov", ov, 0); check("ar inst", io, 0); check("ar op1", op1, 0);
    check("ar ld", ld, 0); check("ar rd", rd, 0); check("ar cnt", cnt, 0);
    check("ar in_ready", rdy, 1);
    model_clear(); m_cnt = 0;
    drive(0, 0, 0, 0, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // randomized stream honouring valid/ready
    for (int n = 0; n < 3000; n++) begin
      if (!(in_valid && !m_rdy)) begin
        inst = gen();
        addr = $urandom & 32'hFFFF_FFFC;
      end
      in_valid = ($urandom_range(0, 3) != 0) || (in_valid && !m_rdy);
      r1d   = $urandom;
      r2d   = $urandom;
      flush = ($urandom_range(0, 31) == 0);
      exr   = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_stage.md
# id_stage

Registered RISC-V RV32I decode stage between the IF/ID register and the execute unit. It decodes one instruction per cycle from a valid/ready input stream and reads source registers through the combinational regfile ports. It detects load-use hazards against the instruction it currently holds and inserts bubbles when one is found. Results are held in an internal ID/EX output register with valid/ready backpressure and flush, so the separate id_ex register is not needed.

## Interface
- XLEN, 32: operand width; must be ≥32; immediates sign-extend to XLEN.
- CNT_W, 16: width of the saturating bubble counter.
- HAZARD_EN, 1: 1 enables load-use bubble insertion; 0 means the hazard signal is never asserted.

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid_i  in  1  inst_i/inst_addr_i valid
- in_ready_o  out  1  stage accepts the input this cycle (combinational)
- inst_i  in  32  instruction word
- inst_addr_i  in  32  instruction address
- rs1_addr_o, rs2_addr_o  out  5 each  regfile read addresses, combinational from inst_i
- rs1_data_i, rs2_data_i  in  XLEN each  regfile read data, same cycle
- flush_i  in  1  kill the held and incoming instruction
- ex_ready_i  in  1  execute accepts the held instruction
- out_valid_o  out  1  held instruction valid
- inst_o, inst_addr_o  out  32 each  held instruction and address
- op1_o, op2_o  out  XLEN each  operands
- imm_o  out  XLEN  decoded immediate (branch/jump offset)
- rd_addr_o  out  5  destination register
- reg_wen_o  out  1  writeback enable
- is_load_o  out  1  held instruction is LW
- illegal_o  out  1  held instruction is not decodable
- stall_cnt_o  out  CNT_W  count of inserted bubbles

## Operation
Decode per class. "sext" means sign-extend to XLEN. For every class, reg_wen = (class writes) && rd≠0.
- OP-IMM (opcode 0010011), all eight funct3 values:
  - op1 = rs1_data; op2 = sext I-imm.
  - For SLLI/SRLI/SRAI, op2 = zero-extended shamt; funct7 stays visible in inst_o.
  - Reads rs1; writes rd.
- OP (0110011), all ten R-type operations: op1 = rs1_data, op2 = rs2_data; reads rs1 and rs2; writes rd.
- BRANCH (1100011), funct3 000/001/100/101/110/111: op1 = rs1_data, op2 = rs2_data, imm = B-imm; rd = 0; no write.
- JAL (1101111): op1 = inst_addr, op2 = 4, imm = J-imm; writes rd.
- JALR (1100111, funct3 000): op1 = rs1_data, op2 = sext I-imm, imm = sext I-imm; writes rd. Execute forms the link as inst_addr_o+4.
- LUI: op1 = 0, op2 = U-imm. AUIPC: op1 = inst_addr, op2 = U-imm. Both write rd.
- LOAD (0000011, funct3 010): op1 = rs1_data, op2 = sext I-imm; writes rd; is_load = 1.
- Anything else:
  - illegal = 1; op1, op2, imm and rd are 0; reg_wen = 0.
  - The instruction is still delivered with out_valid, so execute can trap.
- rs1_addr_o/rs2_addr_o output the field value only for classes that read that source, and 0 otherwise.

Handshake and hazard. Define adv = !out_valid_o || ex_ready_i.
- hazard = HAZARD_EN && in_valid_i && out_valid_o && is_load_o && rd_addr_o≠0 && ((reads rs1 && rs1==rd_addr_o) || (reads rs2 && rs2==rd_addr_o)).
- in_ready_o = flush_i || (adv && !hazard).
- Register update priority:
  1. flush_i: out_valid ← 0 and all held fields ← 0. The input, if valid, is consumed and dropped.
  2. adv && hazard: bubble; out_valid ← 0; stall_cnt += 1, saturating at all-ones.
  3. adv && in_valid_i: load the decoded fields; out_valid ← 1.
  4. adv && !in_valid_i: out_valid ← 0.
  5. Otherwise (!adv): hold every field unchanged.

## Timing
- Latency: an input accepted at edge N appears on the outputs after edge N; one cycle.
- Throughput: one instruction per cycle without hazards.
- Load-use: exactly one bubble. After the bubble the load has left the stage, so the dependent instruction is accepted on the next cycle.
- Reset, asynchronous: out_valid_o, inst_o, inst_addr_o, op1_o, op2_o, imm_o, rd_addr_o, reg_wen_o, is_load_o, illegal_o and stall_cnt_o all go to 0.
  - in_ready_o = 1 while in reset.
  - Reset mid-stall drops the held load and the pending input.
- Flush and ex_ready_i low at the same time: flush wins; out_valid goes to 0 next cycle.
- Held outputs must stay stable while out_valid_o=1 && !ex_ready_i.
- stall_cnt_o does not wrap; it holds at 2^CNT_W−1.

## Test plan
- Reset, then addi x1,x0,5 (0x00500093) with rs1_data=0 → next cycle: out_valid=1, op1=0, op2=5, rd=1, reg_wen=1, illegal=0.
- lw x2,0(x1) (0x0000A103) followed by add x3,x2,x2 (0x002101B3) → one cycle with in_ready=0 and out_valid=0 (bubble), stall_cnt=1; the add is accepted the next cycle with rs1_addr=rs2_addr=2. Repeat with HAZARD_EN=0 → no bubble, stall_cnt stays 0.
- jal x0,8 (0x0080006F) at address 0x100 → op1=0x100, op2=4, imm=8, rd=0, reg_wen=0.
- ex_ready_i=0 for 3 cycles with a valid instruction held → in_ready=0 and outputs unchanged; release → the next instruction appears one cycle later with no loss or duplicate.
- 0xFFFFFFFF → out_valid=1, illegal=1, reg_wen=0, op1=op2=0; flush_i asserted the same cycle as a valid add → add dropped, out_valid=0 next cycle.
- CNT_W=2 with 5 back-to-back load-use pairs → stall_cnt saturates at 3. Assert rst low mid-stall → all outputs 0 immediately (asynchronous).
